fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC and drives the address of the word-addressed
//  instruction memory, which returns its word combinationally in the same cycle.
//  Captures {pc, instruction} pairs into a 2-entry buffer that feeds the decoder
//  over a valid/ready handshake. Accepts PC redirects (branch/jump) from execute.
// PARAMETERS
//  N        32   data/address width
//  RESET_PC 0    PC value loaded on reset (must be 4-byte aligned)
//  DEPTH    2    instruction buffer entries (power of 2, >=2)
// PORTS
//  clk            input   1  rising-edge clock
//  rst            input   1  synchronous active-high reset
//  imem_adr       output  N  byte address to instruction memory (= pc register)
//  imem_data      input   N  instruction word for imem_adr, valid same cycle
//  redirect_valid input   1  execute requests PC change this cycle
//  redirect_pc    input   N  new PC; bits [1:0] forced to 0 on load
//  out_valid      output  1  out_inst/out_pc hold a valid entry
//  out_ready      input   1  decoder consumes the head entry this cycle
//  out_inst       output  N  head-entry instruction
//  out_pc         output  N  head-entry PC
//  fetch_count    output  N  number of words pushed into the buffer since reset
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): pc=RESET_PC, buffer empty, out_valid=0,
//    out_inst=0, out_pc=0, fetch_count=0. Reset overrides all other inputs and
//    discards any in-flight entry.
//  - imem_adr = pc continuously (combinational from the pc register).
//  - pop  = out_valid & out_ready.
//  - push = ~redirect_valid & (count < DEPTH | pop).
//    On push: entry {pc, imem_data} is written at tail; pc <= pc + 4 (mod 2^N,
//    so 32'hFFFF_FFFC wraps to 0); fetch_count <= fetch_count + 1 (wraps).
//    If no push and no redirect, pc holds (stall: buffer full, no pop).
//  - Redirect (redirect_valid=1): buffer flushed (count=0, out_valid=0 next
//    cycle), any same-cycle pop is still honoured by the decoder but the entry
//    is discarded with the rest; pc <= {redirect_pc[N-1:2], 2'b00}; no push.
//  - Latency: word fetched at cycle k appears on out_* at cycle k+1 when the
//    buffer was empty; throughput 1 instr/cycle with out_ready held high.
//  - out_* are driven from the head entry; out_inst/out_pc stay stable while
//    out_valid=1 and out_ready=0.
//  - Simultaneous push and pop when full: both occur, count unchanged.
//  - Simultaneous push and pop when count=1: head advances to the new entry.
//  - count tracked as 0..DEPTH; pointers wrap modulo DEPTH.
// TESTING
//  1 Reset, RESET_PC=0, out_ready=1, imem returns mem[adr>>2] = {A,B,C}
//    -> imem_adr 0,4,8 on cycles 1..3; out (pc,inst)=(0,A),(4,B),(8,C) on cycles 2..4.
//  2 out_ready=0 from cycle 1 -> after 2 pushes pc freezes at 8, out_valid=1,
//    out stays (0,A); release out_ready -> (0,A),(4,B),(8,C) in order, none lost.
//  3 redirect_valid=1, redirect_pc=0x23 at cycle 3 -> next cycle out_valid=0,
//    imem_adr=0x20; cycle after out=(0x20, mem[8]); fetch_count not incremented
//    on redirect cycle.
//  4 Set pc via redirect to 0xFFFFFFFC, out_ready=1 -> imem_adr 0xFFFFFFFC then 0;
//    out_pc sequence 0xFFFFFFFC, 0.
//  5 rst asserted while buffer full and out_ready=0 -> next cycle out_valid=0,
//    imem_adr=RESET_PC, fetch_count=0.
//  6 Full buffer with pop and redirect in the same cycle -> buffer empty next
//    cycle, pc=redirect target, no stale entry ever presented.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Owns the PC, presents it as the instruction-memory byte address, and captures
//   {pc, instruction} pairs into a small FIFO that feeds the decoder over a
//   valid/ready handshake. Execute can redirect the PC, which flushes the FIFO.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_adr        byte address to instruction memory (the pc register)
//   imem_data       instruction word for imem_adr, valid in the same cycle
//   redirect_valid  execute requests a PC change this cycle
//   redirect_pc     new PC; the low two bits are dropped
//   out_valid       head entry valid
//   out_ready       decoder consumes the head entry this cycle
//   out_inst        head-entry instruction (zero when out_valid=0)
//   out_pc          head-entry PC (zero when out_valid=0)
//   fetch_count     words pushed into the buffer since reset (wraps)
module fetch_unit #(
   parameter int unsigned   N        = 32,
   parameter logic [N-1:0]  RESET_PC = '0,
   parameter int unsigned   DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst,
   output logic [N-1:0] imem_adr,
   input  logic [N-1:0] imem_data,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_pc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_inst,
   output logic [N-1:0] out_pc,
   output logic [N-1:0] fetch_count
);

   localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [N-1:0]  pc;
   logic [N-1:0]  buf_pc   [DEPTH];
   logic [N-1:0]  buf_inst [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic          push;
   logic          pop;
   logic [1:0]    redirect_lo_unused;

   assign redirect_lo_unused = redirect_pc[1:0];
   assign imem_adr           = pc;

   always_comb begin
      pop  = out_valid & out_ready;
      // A pop frees a slot in the same cycle, so a full buffer still accepts.
      push = ~redirect_valid & ((count < DEPTH_C) | pop);
   end

   always_comb begin
      out_valid = (count != '0);
      out_inst  = '0;
      out_pc    = '0;
      if (out_valid) begin
         out_inst = buf_inst[head];
         out_pc   = buf_pc[head];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         // A same-cycle pop is seen by the decoder, but the flush discards it anyway.
         pc    <= {redirect_pc[N-1:2], 2'b00};
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            buf_pc[tail]   <= pc;
            buf_inst[tail] <= imem_data;
            tail           <= tail + PW'(1);
            pc             <= pc + N'(4);
            fetch_count    <= fetch_count + N'(1);
         end
         if (pop)
            head <= head + PW'(1);
         if (push && !pop)
            count <= count + (PW+1)'(1);
         else if (pop && !push)
            count <= count - (PW+1)'(1);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
//   Instruction memory is modelled as inst = ~address, so every expected
//   instruction below is the bitwise complement of its PC.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_adr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] fetch_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   fetch_unit #(.N(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_adr       (imem_adr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   assign imem_data = ~imem_adr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc_exp, input logic [31:0] inst_exp);
      check({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
      check({tag, "_pc"},    out_pc,   pc_exp);
      check({tag, "_inst"},  out_inst, inst_exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;

      // 1: streaming fetch with the decoder always ready
      do_reset();
      check("t1_rst_adr",   imem_adr,    32'h0);
      check("t1_rst_valid", {31'b0, out_valid}, 32'h0);
      check("t1_rst_inst",  out_inst,    32'h0);
      check("t1_rst_pc",    out_pc,      32'h0);
      check("t1_rst_cnt",   fetch_count, 32'h0);
      tick();
      check("t1_c2_adr", imem_adr, 32'h4);
      check_out("t1_c2", 32'h0, 32'hFFFF_FFFF);
      tick();
      check("t1_c3_adr", imem_adr, 32'h8);
      check_out("t1_c3", 32'h4, 32'hFFFF_FFFB);
      tick();
      check_out("t1_c4", 32'h8, 32'hFFFF_FFF7);
      check("t1_c4_cnt", fetch_count, 32'd3);

      // 2: backpressure fills the buffer, then drains in order
      do_reset();
      out_ready = 1'b0;
      tick();
      tick();
      check("t2_c3_adr", imem_adr, 32'h8);
      tick();
      check("t2_c4_adr", imem_adr, 32'h8);
      check("t2_c4_cnt", fetch_count, 32'd2);
      check_out("t2_c4", 32'h0, 32'hFFFF_FFFF);
      out_ready = 1'b1;
      tick();
      check_out("t2_c5", 32'h4, 32'hFFFF_FFFB);
      check("t2_c5_adr", imem_adr, 32'hC);
      tick();
      check_out("t2_c6", 32'h8, 32'hFFFF_FFF7);
      tick();
      check_out("t2_c7", 32'hC, 32'hFFFF_FFF3);

      // 3: redirect to an unaligned target
      do_reset();
      tick();
      tick();
      check("t3_c3_cnt", fetch_count, 32'd2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h23;
      tick();
      redirect_valid = 1'b0;
      check("t3_c4_valid", {31'b0, out_valid}, 32'h0);
      check("t3_c4_adr",   imem_adr,    32'h20);
      check("t3_c4_cnt",   fetch_count, 32'd2);
      tick();
      check_out("t3_c5", 32'h20, 32'hFFFF_FFDF);
      check("t3_c5_cnt", fetch_count, 32'd3);

      // 4: PC wraps past the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check("t4_adr_top", imem_adr, 32'hFFFF_FFFC);
      check("t4_valid0",  {31'b0, out_valid}, 32'h0);
      tick();
      check("t4_adr_wrap", imem_adr, 32'h0);
      check_out("t4_a", 32'hFFFF_FFFC, 32'h0000_0003);
      tick();
      check_out("t4_b", 32'h0, 32'hFFFF_FFFF);

      // 5: reset while the buffer is full and stalled
      out_ready = 1'b0;
      tick();
      tick();
      tick();
      check("t5_full_valid", {31'b0, out_valid}, 32'h1);
      do_reset();
      check("t5_valid", {31'b0, out_valid}, 32'h0);
      check("t5_adr",   imem_adr,    32'h0);
      check("t5_cnt",   fetch_count, 32'h0);
      check("t5_pc",    out_pc,      32'h0);

      // 6: pop and redirect together on a full buffer
      tick();
      tick();
      check("t6_full_adr", imem_adr, 32'h8);
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      check("t6_valid", {31'b0, out_valid}, 32'h0);
      check("t6_adr",   imem_adr,    32'h100);
      check("t6_cnt",   fetch_count, 32'd2);
      tick();
      check_out("t6_next", 32'h100, 32'hFFFF_FEFF);
      tick();
      check_out("t6_next2", 32'h104, 32'hFFFF_FEFB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
